hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core; successor to the single-cycle load-use detector.
- Detects load-use hazards between the ID instruction and a load in EX.
- Holds the stall for a parametrised number of cycles (LOAD_LAT) through a small FSM.
- Generates EX-stage operand forwarding selects and honours a pipeline flush.

---
 rtl/hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Load-use hazard controller with multi-cycle stall FSM and EX-stage forwarding selects.
// Define HAZARD_STATS_EN to add saturating stall/hazard statistics counters.
module hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int STAT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_wnum,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] mem_wnum,
  input  logic             wb_reg_write,
  input  logic [REG_W-1:0] wb_wnum,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] load_use_events
`endif
);

  if (LOAD_LAT < 1 || LOAD_LAT > 15 || STAT_W < 1) begin : g_bad_param
    $error("hazard_ctrl: LOAD_LAT must be 1..15 and STAT_W >= 1");
  end

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hz;

  always_comb begin
    hz = ex_mem_read & ex_reg_write & (ex_wnum != '0) &
         ((id_use_rs & (id_rs == ex_wnum)) | (id_use_rt & (id_rt == ex_wnum)));
  end

  // flush overrides everything: squash ID/EX but do not hold the front end
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    if (flush) begin
      bubble_id_ex = 1'b1;
      state_d      = S_IDLE;
      cnt_d        = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          stall_if_id  = hz;
          bubble_id_ex = hz;
          if (hz && (LOAD_LAT > 1)) begin
            state_d = S_WAIT;
            cnt_d   = 4'(LOAD_LAT - 1);
          end
        end
        S_WAIT: begin
          stall_if_id  = 1'b1;
          bubble_id_ex = 1'b1;
          cnt_d        = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_WAIT);

  // MEM/WB forwarding; MEM is younger so it wins, and $0 is never forwarded
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_reg_write && (mem_wnum != '0) && (mem_wnum == ex_rs))
      fwd_a = 2'b01;
    else if (wb_reg_write && (wb_wnum != '0) && (wb_wnum == ex_rs))
      fwd_a = 2'b10;
    if (mem_reg_write && (mem_wnum != '0) && (mem_wnum == ex_rt))
      fwd_b = 2'b01;
    else if (wb_reg_write && (wb_wnum != '0) && (wb_wnum == ex_rt))
      fwd_b = 2'b10;
  end

`ifdef HAZARD_STATS_EN
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] event_cnt_q, event_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    event_cnt_d = event_cnt_q;
    if (stall_if_id && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STAT_ONE;
    if ((state_q == S_IDLE) && hz && !flush && (event_cnt_q != '1))
      event_cnt_d = event_cnt_q + STAT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      event_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      event_cnt_q <= event_cnt_d;
    end
  end

  assign stall_cycles    = stall_cnt_q;
  assign load_use_events = event_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: four instances (LOAD_LAT 1/2/3, plus LOAD_LAT 2 with
// 2-bit statistics) share one stimulus; combinational table then multi-cycle sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [4:0] id_rs, id_rt, ex_wnum, ex_rs, ex_rt, mem_wnum, wb_wnum;
  logic       id_use_rs, id_use_rt, ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write;

  logic       s1, b1, y1, s2, b2, y2, s3, b3, y3, ss, bs, ys;
  logic [1:0] fa1, fb1, fa2, fb2, fa3, fb3, fas, fbs;
`ifdef HAZARD_STATS_EN
  logic [31:0] sc1, ev1, sc2, ev2, sc3, ev3;
  logic [1:0]  scs, evs;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .STAT_W(32)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_wnum(ex_wnum), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_reg_write(mem_reg_write), .mem_wnum(mem_wnum), .wb_reg_write(wb_reg_write),
    .wb_wnum(wb_wnum), .stall_if_id(s1), .bubble_id_ex(b1), .fwd_a(fa1), .fwd_b(fb1),
    .busy(y1)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc1), .load_use_events(ev1)
`endif
  );

  hazard_ctrl #(.REG_W(5), .LOAD_LAT(2), .STAT_W(32)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_wnum(ex_wnum), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_reg_write(mem_reg_write), .mem_wnum(mem_wnum), .wb_reg_write(wb_reg_write),
    .wb_wnum(wb_wnum), .stall_if_id(s2), .bubble_id_ex(b2), .fwd_a(fa2), .fwd_b(fb2),
    .busy(y2)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc2), .load_use_events(ev2)
`endif
  );

  hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .STAT_W(32)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_wnum(ex_wnum), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_reg_write(mem_reg_write), .mem_wnum(mem_wnum), .wb_reg_write(wb_reg_write),
    .wb_wnum(wb_wnum), .stall_if_id(s3), .bubble_id_ex(b3), .fwd_a(fa3), .fwd_b(fb3),
    .busy(y3)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc3), .load_use_events(ev3)
`endif
  );

  hazard_ctrl #(.REG_W(5), .LOAD_LAT(2), .STAT_W(2)) u_ds (
    .clk(clk), .rst(rst), .flush(flush), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_wnum(ex_wnum), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .mem_reg_write(mem_reg_write), .mem_wnum(mem_wnum), .wb_reg_write(wb_reg_write),
    .wb_wnum(wb_wnum), .stall_if_id(ss), .bubble_id_ex(bs), .fwd_a(fas), .fwd_b(fbs),
    .busy(ys)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(scs), .load_use_events(evs)
`endif
  );

  typedef struct {
    logic       flush;
    logic [4:0] id_rs, id_rt;
    logic       use_rs, use_rt, ex_mr, ex_rw;
    logic [4:0] ex_wnum, ex_rs, ex_rt;
    logic       mem_rw;
    logic [4:0] mem_wnum;
    logic       wb_rw;
    logic [4:0] wb_wnum;
    logic       e_stall, e_bubble;
    logic [1:0] e_fa, e_fb;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input int fl, input int rs, input int rt, input int urs,
                              input int urt, input int mr, input int rw, input int wn,
                              input int xrs, input int xrt, input int mrw, input int mwn,
                              input int wrw, input int wwn, input int es, input int eb,
                              input int fa, input int fb);
    vec_t v;
    v.flush = fl[0];       v.id_rs = rs[4:0];     v.id_rt = rt[4:0];
    v.use_rs = urs[0];     v.use_rt = urt[0];     v.ex_mr = mr[0];
    v.ex_rw = rw[0];       v.ex_wnum = wn[4:0];   v.ex_rs = xrs[4:0];
    v.ex_rt = xrt[4:0];    v.mem_rw = mrw[0];     v.mem_wnum = mwn[4:0];
    v.wb_rw = wrw[0];      v.wb_wnum = wwn[4:0];  v.e_stall = es[0];
    v.e_bubble = eb[0];    v.e_fa = fa[1:0];      v.e_fb = fb[1:0];
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    flush = v.flush;       id_rs = v.id_rs;       id_rt = v.id_rt;
    id_use_rs = v.use_rs;  id_use_rt = v.use_rt;  ex_mem_read = v.ex_mr;
    ex_reg_write = v.ex_rw; ex_wnum = v.ex_wnum;  ex_rs = v.ex_rs;
    ex_rt = v.ex_rt;       mem_reg_write = v.mem_rw; mem_wnum = v.mem_wnum;
    wb_reg_write = v.wb_rw; wb_wnum = v.wb_wnum;
  endtask

  task automatic set_idle();
    apply(mk(0, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0, 0,0, 0,0));
  endtask

  // EX: lw $8 ; ID: add reading $8 through rs
  task automatic set_hz();
    apply(mk(0, 8,0, 1,0, 1,1,8, 0,0, 0,0, 0,0, 1,1, 0,0));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // expected {stall, bubble, busy} per instance (LOAD_LAT 1, 2, 3); the STAT_W=2
  // instance shares the LOAD_LAT=2 expectation
  task automatic chk(input string nm, input logic [2:0] e1, input logic [2:0] e2,
                     input logic [2:0] e3);
    @(negedge clk);
    cmp({nm, " lat1"}, {29'd0, s1, b1, y1}, {29'd0, e1});
    cmp({nm, " lat2"}, {29'd0, s2, b2, y2}, {29'd0, e2});
    cmp({nm, " lat3"}, {29'd0, s3, b3, y3}, {29'd0, e3});
    cmp({nm, " lat2s"}, {29'd0, ss, bs, ys}, {29'd0, e2});
  endtask

  task automatic seq_pulse(input string nm);
    next_cycle(); set_hz();   chk({nm, " c1"}, 3'b110, 3'b110, 3'b110);
    next_cycle(); set_idle(); chk({nm, " c2"}, 3'b000, 3'b111, 3'b111);
    next_cycle();             chk({nm, " c3"}, 3'b000, 3'b000, 3'b111);
    next_cycle();             chk({nm, " c4"}, 3'b000, 3'b000, 3'b000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0, 8,0, 1,0, 1,1,8, 0,0, 0,0, 0,0, 1,1, 0,0);
    vecs[1]  = mk(0, 3,8, 0,1, 1,1,8, 0,0, 0,0, 0,0, 1,1, 0,0);
    vecs[2]  = mk(0, 0,0, 1,1, 1,1,0, 0,0, 0,0, 0,0, 0,0, 0,0);
    vecs[3]  = mk(0, 4,8, 1,0, 1,1,8, 0,0, 0,0, 0,0, 0,0, 0,0);
    vecs[4]  = mk(0, 8,0, 1,0, 0,1,8, 0,0, 0,0, 0,0, 0,0, 0,0);
    vecs[5]  = mk(0, 8,0, 1,0, 1,0,8, 0,0, 0,0, 0,0, 0,0, 0,0);
    vecs[6]  = mk(1, 8,0, 1,0, 1,1,8, 0,0, 0,0, 0,0, 0,1, 0,0);
    vecs[7]  = mk(1, 0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0, 0,1, 0,0);
    vecs[8]  = mk(0, 0,0, 0,0, 0,0,0, 5,7, 1,5, 1,5, 0,0, 1,0);
    vecs[9]  = mk(0, 0,0, 0,0, 0,0,0, 5,7, 0,5, 1,5, 0,0, 2,0);
    vecs[10] = mk(0, 0,0, 0,0, 0,0,0, 0,0, 1,0, 1,0, 0,0, 0,0);
    vecs[11] = mk(0, 0,0, 0,0, 0,0,0, 9,9, 1,9, 1,9, 0,0, 1,1);
    vecs[12] = mk(0, 0,0, 0,0, 0,0,0, 3,9, 1,3, 1,9, 0,0, 1,2);
    vecs[13] = mk(0, 6,6, 1,1, 1,1,6, 6,2, 0,6, 1,2, 1,1, 0,2);
    vecs[14] = mk(0, 0,0, 0,0, 0,0,0, 7,4, 1,7, 0,4, 0,0, 1,0);

    rst = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset", 3'b000, 3'b000, 3'b000);
    cmp("reset fwd", {28'd0, fa1, fb1}, 32'd0);
`ifdef HAZARD_STATS_EN
    cmp("reset stall_cycles", sc2, 32'd0);
    cmp("reset load_use_events", ev2, 32'd0);
`endif

    // combinational table on the LOAD_LAT=1 instance, which never leaves IDLE
    for (int i = 0; i < 15; i++) begin
      next_cycle();
      apply(vecs[i]);
      @(negedge clk);
      cmp($sformatf("vec%0d stall/bubble/busy", i), {29'd0, s1, b1, y1},
          {29'd0, vecs[i].e_stall, vecs[i].e_bubble, 1'b0});
      cmp($sformatf("vec%0d fwd_a", i), {30'd0, fa1}, {30'd0, vecs[i].e_fa});
      cmp($sformatf("vec%0d fwd_b", i), {30'd0, fb1}, {30'd0, vecs[i].e_fb});
    end

    next_cycle(); set_idle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    chk("post-table reset", 3'b000, 3'b000, 3'b000);

    seq_pulse("hazard A");
    seq_pulse("hazard B");
`ifdef HAZARD_STATS_EN
    cmp("lat2 events after 2", ev2, 32'd2);
    cmp("lat2 stalls after 2", sc2, 32'd4);
    cmp("lat1 stalls after 2", sc1, 32'd2);
    cmp("lat3 stalls after 2", sc3, 32'd6);
    cmp("lat2s events after 2", {30'd0, evs}, 32'd2);
    cmp("lat2s stalls saturate", {30'd0, scs}, 32'd3);
`endif

    // ID frozen on the dependent instruction for 3 cycles: LOAD_LAT=2 sees it twice
    next_cycle(); set_hz();   chk("held c1", 3'b110, 3'b110, 3'b110);
    next_cycle();             chk("held c2", 3'b110, 3'b111, 3'b111);
    next_cycle();             chk("held c3", 3'b110, 3'b110, 3'b111);
    next_cycle(); set_idle(); chk("held c4", 3'b000, 3'b111, 3'b000);
    next_cycle();             chk("held c5", 3'b000, 3'b000, 3'b000);
`ifdef HAZARD_STATS_EN
    cmp("lat2 events after held", ev2, 32'd4);
    cmp("lat2 stalls after held", sc2, 32'd8);
    cmp("lat1 events after held", ev1, 32'd5);
    cmp("lat3 events after held", ev3, 32'd3);
    cmp("lat2s events saturate", {30'd0, evs}, 32'd3);
`endif

    next_cycle(); set_hz();   chk("flush c1", 3'b110, 3'b110, 3'b110);
    next_cycle(); set_idle(); flush = 1'b1;
    chk("flush c2", 3'b010, 3'b011, 3'b011);
    next_cycle(); flush = 1'b0;
    chk("flush c3", 3'b000, 3'b000, 3'b000);

    next_cycle(); set_hz();   chk("rst c1", 3'b110, 3'b110, 3'b110);
    next_cycle(); set_idle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    chk("rst c3", 3'b000, 3'b000, 3'b000);
`ifdef HAZARD_STATS_EN
    cmp("rst clears stall_cycles", sc2, 32'd0);
    cmp("rst clears load_use_events", ev2, 32'd0);
    cmp("rst clears lat2s stalls", {30'd0, scs}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
